// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - Default geometry and latency for dmem_responder.
//   - FSM state encoding (2 bits: idle, wait, resp).
//   - cnt_width(): width of the wait-state down-counter.
package dmem_responder_pkg;

   localparam int unsigned DefWordWidth  = 32;
   localparam int unsigned DefDepthLog2  = 10;
   localparam int unsigned DefWaitStates = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } dmem_state_e;

   // Wide enough to hold WAIT_STATES and never zero bits wide, even when WAIT_STATES == 0.
   function automatic int unsigned cnt_width(input int unsigned wait_states);
      return $clog2(wait_states + 2);
   endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous data array with byte-enabled write and registered read.
// Each byte lane is its own memory so per-byte enables map onto independent write strobes.
// Ports:
//   clk    in   clock
//   en     in   access strobe for this cycle
//   we     in   1 = write enabled bytes, 0 = read word into rdata
//   idx    in   word index
//   wdata  in   write data
//   be     in   byte enables, bit i covers byte i
//   rdata  out  registered read data; holds until the next read
module dmem_sram_array #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [DEPTH_LOG2-1:0]   idx,
   input  logic [WORD_WIDTH-1:0]   wdata,
   input  logic [WORD_WIDTH/8-1:0] be,
   output logic [WORD_WIDTH-1:0]   rdata
);

   localparam int unsigned BeW   = WORD_WIDTH / 8;
   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   for (genvar g = 0; g < BeW; g++) begin : g_lane
      logic [7:0] mem_q [Depth];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (en) begin
            if (we) begin
               if (be[g]) begin
                  mem_q[idx] <= wdata[8*g +: 8];
               end
            end else begin
               rd_q <= mem_q[idx];
            end
         end
      end

      assign rdata[8*g +: 8] = rd_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store request interface.
// Accepts one word request per handshake, waits WAIT_STATES cycles, then commits the access
// and raises resp_valid for one cycle. The response channel has no backpressure.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag req_addr[1:0] != 0 as a misaligned
// access (no array access, resp_err = 1, resp_rdata = 0). Without it resp_err is always 0.
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address (wraps modulo 4 * 2^DEPTH_LOG2)
//   req_wdata   in   store data
//   req_be      in   store byte enables
//   resp_valid  out  one-cycle response strobe
//   resp_rdata  out  load data, 0 after stores; held until the next response
//   resp_err    out  misaligned access flag
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = DefWordWidth,
   parameter int unsigned DEPTH_LOG2  = DefDepthLog2,
   parameter int unsigned WAIT_STATES = DefWaitStates
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [WORD_WIDTH-1:0]   req_addr,
   input  logic [WORD_WIDTH-1:0]   req_wdata,
   input  logic [WORD_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   output logic [WORD_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int unsigned BeW  = WORD_WIDTH / 8;
   localparam int unsigned CntW = cnt_width(WAIT_STATES);

   dmem_state_e           state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  accept, commit, mis_req;
   logic [DEPTH_LOG2-1:0] req_idx;

   // Request captured at accept
   logic                  we_q, mis_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [BeW-1:0]        be_q;

   // Response registers
   logic                  resp_valid_q, resp_load_q, resp_err_q;

   // Array port
   logic                  arr_en, arr_we, arr_mis;
   logic [DEPTH_LOG2-1:0] arr_idx;
   logic [WORD_WIDTH-1:0] arr_wdata, arr_rdata;
   logic [BeW-1:0]        arr_be;

   // Upper address bits are deliberately ignored (address wrap).
   logic unused_addr;
   assign unused_addr = ^req_addr;

   assign req_ready = (state_q == StIdle);
   assign accept    = req_valid && req_ready;
   assign req_idx   = req_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis_req = (req_addr[1:0] != 2'b00);
`else
   assign mis_req = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d = CntW'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StResp;
               commit  = 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // With zero wait states the commit edge is the accept edge, so the array must see the
   // live request rather than the captured copy.
   always_comb begin
      if (state_q == StIdle) begin
         arr_we    = req_we;
         arr_idx   = req_idx;
         arr_wdata = req_wdata;
         arr_be    = req_be;
         arr_mis   = mis_req;
      end else begin
         arr_we    = we_q;
         arr_idx   = idx_q;
         arr_wdata = wdata_q;
         arr_be    = be_q;
         arr_mis   = mis_q;
      end
   end

   // Reset on the commit edge drops the transaction, including its write.
   assign arr_en = commit && !rst && !arr_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_load_q  <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= commit;
         if (commit) begin
            resp_load_q <= !arr_we && !arr_mis;
            resp_err_q  <= arr_mis;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         mis_q   <= mis_req;
         idx_q   <= req_idx;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   dmem_sram_array #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .be    (arr_be),
      .rdata (arr_rdata)
   );

   // The array's read register doubles as the response data register; stores and
   // misaligned accesses report zero instead.
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_load_q ? arr_rdata : '0;
   assign resp_err   = resp_err_q;

endmodule
